// File: rtl/gate_result_buffer.sv
// FWFT result buffer behind the bitwise gate stage: valid/ready in, valid/ready out.
// Optional statistics counters are built when GATE_RESULT_STATS_EN is defined.
module gate_result_buffer #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           ones_cnt,
  output logic [CNT_W-1:0]           total_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_alive;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // r_alive keeps in_ready low until the first edge after reset release
  assign in_ready  = r_alive & ~w_full & ~flush;
  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign level     = r_wr_ptr - r_rd_ptr;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive  <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_alive <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Storage is reset so out_data reads zero while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

`ifdef GATE_RESULT_STATS_EN
  logic [CNT_W-1:0] r_ones_cnt;
  logic [CNT_W-1:0] r_total_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_cnt  <= '0;
      r_total_cnt <= '0;
    end else if (w_push) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + CNT_W'(1);
      if ((in_data == '1) && (r_ones_cnt != '1)) r_ones_cnt <= r_ones_cnt + CNT_W'(1);
    end
  end

  assign ones_cnt  = r_ones_cnt;
  assign total_cnt = r_total_cnt;
`else
  assign ones_cnt  = '0;
  assign total_cnt = '0;
`endif

endmodule

// File: tb/tb_gate_result_buffer.sv
// Self-checking bench for gate_result_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_gate_result_buffer;

  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic [CNT_W-1:0]  ones_cnt;
  logic [CNT_W-1:0]  total_cnt;

  gate_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .ones_cnt(ones_cnt), .total_cnt(total_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DATA_W-1:0] q[$];
  bit alive = 0;
  int m_tot = 0;
  int m_ones = 0;

  function automatic bit exp_ready();
    return alive && (q.size() < DEPTH) && !flush && rst_n;
  endfunction

  function automatic int exp_tot();
`ifdef GATE_RESULT_STATS_EN
    return m_tot;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ones();
`ifdef GATE_RESULT_STATS_EN
    return m_ones;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
  endtask

  // Apply the current inputs to the model, then let the DUT take the edge.
  task automatic step();
    bit push, pop;
    push = in_valid && exp_ready();
    pop  = (q.size() > 0) && out_ready && !flush;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
    if (push) begin
      m_tot = (m_tot < CMAX) ? m_tot + 1 : CMAX;
      if (in_data == '1) m_ones = (m_ones < CMAX) ? m_ones + 1 : CMAX;
    end
    alive = rst_n;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0;
    q.delete(); alive = 0; m_tot = 0; m_ones = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_data !== 2'b00) begin bad++; $display("FAIL reset_out_data got=%b exp=00", out_data); end
    total++; if (total_cnt !== 2'd0 || ones_cnt !== 2'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", total_cnt, ones_cnt); end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", in_ready); end
    step();
    drive(0, 0, 0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", in_ready); end
  endtask

  task automatic test_order();
    logic [DATA_W-1:0] words [3];
    words[0] = 2'b11; words[1] = 2'b01; words[2] = 2'b10;
    drive(1, words[0], 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_no_bypass got=%b exp=0", out_valid); end
    step();
    drive(1, words[1], 0, 0); step();
    drive(1, words[2], 0, 0); step();
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL order_level got=%0d exp=3", level); end
    total++; if (out_valid !== 1'b1 || out_data !== 2'b11) begin bad++; $display("FAIL order_head got=%b/%b exp=1/11", out_valid, out_data); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      total++; if (out_valid !== 1'b1 || out_data !== words[i]) begin bad++; $display("FAIL order_pop%0d got=%b/%b exp=1/%b", i, out_valid, out_data, words[i]); end
      step();
    end
    drive(0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL order_drained got=%b/%0d exp=0/0", out_valid, level); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, DATA_W'(i), 0, 0); step();
    end
    drive(0, 0, 0, 0);
    total++; if (in_ready !== 1'b0 || level !== 3'd4) begin bad++; $display("FAIL full_state got=%b/%0d exp=0/4", in_ready, level); end
    drive(1, 2'b11, 1, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%b exp=0", in_ready); end
    step();
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd3 || out_data !== 2'd1) begin bad++; $display("FAIL full_refused got=%0d/%b exp=3/01", level, out_data); end
    while (q.size() > 0) begin drive(0, 0, 1, 0); step(); end
  endtask

  task automatic test_wrap();
    drive(1, 2'b10, 0, 0); step();
    drive(1, 2'b01, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1, DATA_W'($urandom), 1, 0);
      total++; if (level !== 3'd2 || out_data !== q[0]) begin bad++; $display("FAIL wrap_%0d got=%0d/%b exp=2/%b", i, level, out_data, q[0]); end
      step();
    end
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level got=%0d exp=2", level); end
    while (q.size() > 0) begin drive(0, 0, 1, 0); step(); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 2'b01, 0, 0); step(); end
    drive(1, 2'b11, 1, 1);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    step();
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", level, out_valid); end
    drive(1, 2'b10, 0, 0); step();
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd1 || out_data !== 2'b10) begin bad++; $display("FAIL flush_refill got=%0d/%b exp=1/10", level, out_data); end
    total++; if (total_cnt !== CNT_W'(exp_tot())) begin bad++; $display("FAIL flush_keeps_stats got=%0d exp=%0d", total_cnt, exp_tot()); end
  endtask

  task automatic test_async_reset();
    drive(1, 2'b01, 0, 0); step();
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    q.delete(); alive = 0; m_tot = 0; m_ones = 0;
    #1;
    total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL async_reset got=%b/%0d exp=0/0", out_valid, level); end
    total++; if (out_data !== 2'b00 || in_ready !== 1'b0) begin bad++; $display("FAIL async_reset_data got=%b/%b exp=00/0", out_data, in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
    drive(1, 2'b01, 0, 0); step();
    drive(0, 0, 0, 0);
    total++; if (level !== 3'd1 || out_data !== 2'b01) begin bad++; $display("FAIL async_refill got=%0d/%b exp=1/01", level, out_data); end
  endtask

  task automatic test_stats();
    int et, eo;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b11, 1, 0); step();
    end
    drive(1, 2'b01, 1, 0); step();
    drive(0, 0, 0, 0);
`ifdef GATE_RESULT_STATS_EN
    et = 3; eo = 3;
`else
    et = 0; eo = 0;
`endif
    total++; if (total_cnt !== CNT_W'(et)) begin bad++; $display("FAIL stats_total got=%0d exp=%0d", total_cnt, et); end
    total++; if (ones_cnt !== CNT_W'(eo)) begin bad++; $display("FAIL stats_ones got=%0d exp=%0d", ones_cnt, eo); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      total++;
      if (in_ready !== exp_ready() || out_valid !== (q.size() > 0) || level !== 3'(q.size()) ||
          (q.size() > 0 && out_data !== q[0]) ||
          total_cnt !== CNT_W'(exp_tot()) || ones_cnt !== CNT_W'(exp_ones())) begin
        bad++;
        $display("FAIL random_%0d got rdy=%b v=%b lvl=%0d d=%b t=%0d o=%0d exp rdy=%b v=%b lvl=%0d d=%b t=%0d o=%0d",
                 i, in_ready, out_valid, level, out_data, total_cnt, ones_cnt,
                 exp_ready(), q.size() > 0, q.size(), (q.size() > 0) ? q[0] : 2'b00, exp_tot(), exp_ones());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_wrap();
    test_flush();
    test_async_reset();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
